// File: rtl/pid_controller_v2.sv
// Four-stage pipelined PID controller with a saturating integrator, anti-windup and a clamped output.
// The derivative path is built only when the macro PID_DERIVATIVE_EN is defined.
module pid_controller_v2 #(
  parameter int DATA_WIDTH = 14,
  parameter int COEF_WIDTH = 16,
  parameter int INT_WIDTH  = 32,
  parameter int SHIFT      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic signed [DATA_WIDTH-1:0] set_point,
  input  logic signed [COEF_WIDTH-1:0] p_coef,
  input  logic signed [COEF_WIDTH-1:0] i_coef,
  input  logic signed [COEF_WIDTH-1:0] d_coef,
  input  logic signed [DATA_WIDTH-1:0] out_min,
  input  logic signed [DATA_WIDTH-1:0] out_max,
  input  logic                         integ_clear,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic [1:0]                   saturated
);

  localparam int EW  = DATA_WIDTH + 1;
  localparam int DW2 = DATA_WIDTH + 2;
  localparam int PW  = EW + COEF_WIDTH;
  localparam int DPW = DW2 + COEF_WIDTH;
  localparam int MW  = (INT_WIDTH > DPW) ? INT_WIDTH : DPW;
  localparam int SW  = MW + 2;

  localparam logic signed [SW-1:0] INT_MAX_W = SW'({1'b0, {(INT_WIDTH-1){1'b1}}});
  localparam logic signed [SW-1:0] INT_MIN_W = ~INT_MAX_W;

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, out_valid_q, out_valid_d;
  logic signed [EW-1:0]         error_q, error_d, error_new;
  logic signed [COEF_WIDTH-1:0] p_coef_q, p_coef_d, i_coef_q, i_coef_d;
  logic signed [PW-1:0]         p_q, p_d, i_step_q, i_step_d, p3_q, p3_d;
  logic signed [INT_WIDTH-1:0]  integ_q, integ_d;
  logic signed [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [1:0]                   saturated_q, saturated_d;

  logic signed [SW-1:0] integ_sum, sum_w, shifted, clamped, omin_w, omax_w, d3_w;
  logic                 hold, sat_hi, sat_lo;

`ifdef PID_DERIVATIVE_EN
  logic signed [EW-1:0]         prev_error_q, prev_error_d;
  logic signed [DW2-1:0]        delta_q, delta_d;
  logic signed [COEF_WIDTH-1:0] d_coef_q, d_coef_d;
  logic signed [DPW-1:0]        d_q, d_d, d3_q, d3_d;
`else
  logic unused_d_coef;
  assign unused_d_coef = ^d_coef;
`endif

  always_comb begin
    v1_d        = in_valid;
    v2_d        = v1_q;
    v3_d        = v2_q;
    out_valid_d = v3_q;

    error_new = EW'(set_point) - EW'(data_in);
    error_d   = error_q;
    p_coef_d  = p_coef_q;
    i_coef_d  = i_coef_q;
    if (in_valid) begin
      error_d  = error_new;
      p_coef_d = p_coef;
      i_coef_d = i_coef;
    end

    p_d      = p_q;
    i_step_d = i_step_q;
    if (v1_q) begin
      p_d      = PW'(error_q) * PW'(p_coef_q);
      i_step_d = PW'(error_q) * PW'(i_coef_q);
    end

`ifdef PID_DERIVATIVE_EN
    prev_error_d = prev_error_q;
    delta_d      = delta_q;
    d_coef_d     = d_coef_q;
    if (in_valid) begin
      delta_d      = DW2'(error_new) - DW2'(prev_error_q);
      prev_error_d = error_new;
      d_coef_d     = d_coef;
    end
    if (integ_clear) prev_error_d = '0;
    d_d  = v1_q ? DPW'(delta_q) * DPW'(d_coef_q) : d_q;
    d3_d = v2_q ? d_q : d3_q;
    d3_w = SW'(d3_q);
`else
    d3_w = '0;
`endif

    // Anti-windup looks at the last saturation flags actually issued on the output.
    hold      = (saturated_q[1] && !i_step_q[PW-1] && (i_step_q != '0)) ||
                (saturated_q[0] && i_step_q[PW-1]);
    integ_sum = SW'(integ_q) + SW'(i_step_q);
    if (integ_sum > INT_MAX_W)      integ_sum = INT_MAX_W;
    else if (integ_sum < INT_MIN_W) integ_sum = INT_MIN_W;
    integ_d = integ_q;
    if (v2_q && !hold) integ_d = integ_sum[INT_WIDTH-1:0];
    if (integ_clear)   integ_d = '0;
    p3_d = v2_q ? p_q : p3_q;

    sum_w   = SW'(p3_q) + SW'(integ_q) + d3_w;
    shifted = sum_w >>> SHIFT;
    omax_w  = SW'(out_max);
    omin_w  = SW'(out_min);
    clamped = shifted;
    sat_hi  = 1'b0;
    sat_lo  = 1'b0;
    if (clamped > omax_w) begin
      clamped = omax_w;
      sat_hi  = 1'b1;
    end
    // The minimum is applied last so it dominates when the limits are inverted.
    if (clamped < omin_w) begin
      clamped = omin_w;
      sat_lo  = 1'b1;
      sat_hi  = 1'b0;
    end
    data_out_d  = data_out_q;
    saturated_d = saturated_q;
    if (v3_q) begin
      data_out_d  = clamped[DATA_WIDTH-1:0];
      saturated_d = {sat_hi, sat_lo};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      error_q     <= '0;
      p_coef_q    <= '0;
      i_coef_q    <= '0;
      p_q         <= '0;
      i_step_q    <= '0;
      p3_q        <= '0;
      integ_q     <= '0;
      data_out_q  <= '0;
      saturated_q <= '0;
`ifdef PID_DERIVATIVE_EN
      prev_error_q <= '0;
      delta_q      <= '0;
      d_coef_q     <= '0;
      d_q          <= '0;
      d3_q         <= '0;
`endif
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      out_valid_q <= out_valid_d;
      error_q     <= error_d;
      p_coef_q    <= p_coef_d;
      i_coef_q    <= i_coef_d;
      p_q         <= p_d;
      i_step_q    <= i_step_d;
      p3_q        <= p3_d;
      integ_q     <= integ_d;
      data_out_q  <= data_out_d;
      saturated_q <= saturated_d;
`ifdef PID_DERIVATIVE_EN
      prev_error_q <= prev_error_d;
      delta_q      <= delta_d;
      d_coef_q     <= d_coef_d;
      d_q          <= d_d;
      d3_q         <= d3_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign saturated = saturated_q;

endmodule

// File: tb/tb_pid_controller_v2.sv
// Directed-vector bench for pid_controller_v2; expected values are hand-computed for the default parameters.
module tb_pid_controller_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, in_valid, integ_clear;
  logic signed [13:0]  data_in, set_point, out_min, out_max;
  logic signed [15:0]  p_coef, i_coef, d_coef;
  logic                out_valid;
  logic signed [13:0]  data_out;
  logic [1:0]          saturated;

  int tests  = 0;
  int failed = 0;

  pid_controller_v2 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .data_in(data_in), .set_point(set_point),
    .p_coef(p_coef), .i_coef(i_coef), .d_coef(d_coef),
    .out_min(out_min), .out_max(out_max), .integ_clear(integ_clear),
    .out_valid(out_valid), .data_out(data_out), .saturated(saturated)
  );

  task automatic applyStimulus(input logic v, input int sp, input int din,
                               input int p, input int i, input int d);
    @(negedge clk);
    in_valid  = v;
    set_point = 14'(sp);
    data_in   = 14'(din);
    p_coef    = 16'(p);
    i_coef    = 16'(i);
    d_coef    = 16'(d);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst         = 1'b1;
    in_valid    = 1'b0;
    integ_clear = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  int dexp[3];

  initial begin
    rst = 1'b1; in_valid = 1'b0; integ_clear = 1'b0;
    data_in = '0; set_point = '0; p_coef = '0; i_coef = '0; d_coef = '0;
    out_min = -14'sd8192; out_max = 14'sd8191;

    @(negedge clk);
    checkOutput("reset_valid", 32'(out_valid), 0);
    checkOutput("reset_data", 32'(data_out), 0);
    checkOutput("reset_sat", 32'(saturated), 0);
    rst = 1'b0;

    // Proportional only: error 100 * 256 >> 8 = 100.
    applyStimulus(1'b1, 1000, 900, 256, 0, 0);
    idleCycles(3);
    checkOutput("p_early_valid", 32'(out_valid), 0);
    idleCycles(1);
    checkOutput("p_valid", 32'(out_valid), 1);
    checkOutput("p_data", 32'(data_out), 100);
    checkOutput("p_sat", 32'(saturated), 0);
    idleCycles(1);
    checkOutput("p_valid_drop", 32'(out_valid), 0);
    checkOutput("p_hold", 32'(data_out), 100);

    // Integral ramp: each sample adds 10*256 to the integrator.
    doReset();
    for (int t = 0; t < 10; t++) begin
      applyStimulus(t < 6, 10, 0, 0, 256, 0);
      if (t >= 4) checkOutput("ramp", 32'(data_out), 10 * (t - 3));
    end
    idleCycles(1);
    checkOutput("ramp_gap_valid", 32'(out_valid), 0);
    checkOutput("ramp_gap_hold", 32'(data_out), 60);
    @(negedge clk); integ_clear = 1'b1;
    @(negedge clk); integ_clear = 1'b0;
    for (int t = 0; t < 7; t++) begin
      applyStimulus(t < 3, 10, 0, 0, 256, 0);
      if (t >= 4) checkOutput("ramp_after_clear", 32'(data_out), 10 * (t - 3));
    end

    // Upper clamp and anti-windup: the integrator reaches 8000 once, then holds.
    doReset();
    applyStimulus(1'b1, 8000, 0, 512, 1, 0);
    idleCycles(4);
    checkOutput("clamp_hi_data", 32'(data_out), 8191);
    checkOutput("clamp_hi_sat", 32'(saturated), 2);
    applyStimulus(1'b1, 8000, 0, 512, 1, 0);
    idleCycles(4);
    checkOutput("clamp_hi_data2", 32'(data_out), 8191);
    checkOutput("clamp_hi_sat2", 32'(saturated), 2);
    applyStimulus(1'b1, 8000, 0, 0, 0, 0);
    idleCycles(4);
    checkOutput("windup_hold", 32'(data_out), 31);
    checkOutput("windup_sat", 32'(saturated), 0);

    // Lower clamp and floor behaviour of the arithmetic shift.
    doReset();
    applyStimulus(1'b1, -8000, 0, 512, 0, 0);
    idleCycles(4);
    checkOutput("clamp_lo_data", 32'(data_out), -8192);
    checkOutput("clamp_lo_sat", 32'(saturated), 1);
    applyStimulus(1'b1, -1, 0, 1, 0, 0);
    idleCycles(4);
    checkOutput("floor_shift", 32'(data_out), -1);
    checkOutput("floor_sat", 32'(saturated), 0);

    // Derivative step 0 -> 50 -> 50.
`ifdef PID_DERIVATIVE_EN
    dexp = '{0, 50, 0};
`else
    dexp = '{0, 0, 0};
`endif
    doReset();
    for (int t = 0; t < 7; t++) begin
      applyStimulus(t < 3, (t == 0) ? 0 : 50, 0, 0, 0, 256);
      if (t >= 4) checkOutput("deriv", 32'(data_out), dexp[t - 4]);
    end

    // Reset mid-stream discards the in-flight sample.
    applyStimulus(1'b1, 1000, 900, 256, 0, 0);
    idleCycles(4);
    checkOutput("pre_reset_data", 32'(data_out), 100);
    applyStimulus(1'b1, 1000, 900, 256, 0, 0);
    idleCycles(1);
    @(negedge clk); rst = 1'b1; in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      idleCycles(1);
      checkOutput("flush_valid", 32'(out_valid), 0);
    end
    checkOutput("flush_data", 32'(data_out), 0);

    // Inverted limits: out_min wins.
    out_min = 14'sd100; out_max = 14'sd50;
    applyStimulus(1'b1, 0, 0, 0, 0, 0);
    idleCycles(4);
    checkOutput("inverted_limits", 32'(data_out), 100);
    out_min = -14'sd8192; out_max = 14'sd8191;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
